// File: rtl/inst_queue_if.sv
// Bundle of write, pop, flush and status signals shared between the fetch
// front-end (master) and the instruction queue (slave).
interface inst_queue_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 5
);
   logic              flush;
   logic              flush_keep_ds;
   logic              master_is_branch;
   logic              we1;
   logic              we2;
   logic [DATA_W-1:0] wdata1;
   logic [DATA_W-1:0] wdata2;
   logic [ADDR_W-1:0] waddr1;
   logic [ADDR_W-1:0] waddr2;
   logic              re1;
   logic              re2;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic              rvalid1;
   logic              rvalid2;
   logic              ds_out1;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              almost_empty;
   logic              full;
   logic              overflow;
   logic [63:0]       issued_cnt;

   modport master (
      output flush, flush_keep_ds, master_is_branch,
      output we1, we2, wdata1, wdata2, waddr1, waddr2, re1, re2,
      input  rdata1, rdata2, raddr1, raddr2, rvalid1, rvalid2, ds_out1,
      input  count, empty, almost_empty, full, overflow, issued_cnt
   );

   modport slave (
      input  flush, flush_keep_ds, master_is_branch,
      input  we1, we2, wdata1, wdata2, waddr1, waddr2, re1, re2,
      output rdata1, rdata2, raddr1, raddr2, rvalid1, rvalid2, ds_out1,
      output count, empty, almost_empty, full, overflow, issued_cnt
   );
endinterface

// File: rtl/inst_queue.sv
// Dual-issue instruction queue: 2-wide push/pop FIFO of {instr, PC} with a
// delay-slot holding register that survives a branch flush.
module inst_queue #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input logic         clk,
   input logic         rst_n,
   inst_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {NORMAL, DS_WAIT, DS_HOLD} state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic [DATA_W-1:0] r_memData [DEPTH];
   logic [ADDR_W-1:0] r_memAddr [DEPTH];
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [CNT_W-1:0]  r_count;
   logic              r_brPend;
   logic              r_overflow;
   logic [63:0]       r_issuedCnt;
   logic [DATA_W-1:0] r_dsData;
   logic [ADDR_W-1:0] r_dsAddr;

   logic [PTR_W-1:0]  w_wrPtrPlus1;
   logic [PTR_W-1:0]  w_rdPtrPlus1;
   logic              w_geOne;
   logic              w_geTwo;
   logic              w_full;
   logic              w_fifoClear;
   logic [1:0]        w_pushN;
   logic [1:0]        w_popN;
   logic [1:0]        w_issueN;
   logic              w_wrAEn;
   logic              w_wrBEn;
   logic [DATA_W-1:0] w_wrAData;
   logic [ADDR_W-1:0] w_wrAAddr;
   logic              w_dsLoad;
   logic [DATA_W-1:0] w_dsLoadData;
   logic [ADDR_W-1:0] w_dsLoadAddr;
   logic              w_brPendNext;
   logic              w_overflowSet;

   assign w_wrPtrPlus1 = r_wrPtr + 1'b1;
   assign w_rdPtrPlus1 = r_rdPtr + 1'b1;
   assign w_geOne      = (r_count != '0);
   assign w_geTwo      = (r_count > CNT_W'(1));
   assign w_full       = (r_count > CNT_W'(DEPTH - 2));

   // Flush has priority over every same-cycle write and pop; in DS_WAIT the
   // first write goes to the delay-slot register and only wdata2 reaches the FIFO.
   always_comb begin
      w_stateNext   = r_state;
      w_fifoClear   = 1'b0;
      w_pushN       = 2'd0;
      w_popN        = 2'd0;
      w_issueN      = 2'd0;
      w_wrAEn       = 1'b0;
      w_wrBEn       = 1'b0;
      w_wrAData     = bus.wdata1;
      w_wrAAddr     = bus.waddr1;
      w_dsLoad      = 1'b0;
      w_dsLoadData  = bus.wdata1;
      w_dsLoadAddr  = bus.waddr1;
      w_brPendNext  = r_brPend;
      w_overflowSet = 1'b0;
      if (bus.flush) begin
         w_fifoClear  = 1'b1;
         w_brPendNext = 1'b0;
         w_stateNext  = NORMAL;
         if (bus.flush_keep_ds) begin
            if (w_geTwo) begin
               w_dsLoad     = 1'b1;
               w_dsLoadData = r_memData[w_rdPtrPlus1];
               w_dsLoadAddr = r_memAddr[w_rdPtrPlus1];
               w_stateNext  = DS_HOLD;
            end else if (bus.we1) begin
               w_dsLoad    = 1'b1;
               w_stateNext = DS_HOLD;
            end else begin
               w_stateNext = DS_WAIT;
            end
         end
      end else if (r_state == DS_WAIT) begin
         if (bus.we1) begin
            w_dsLoad    = 1'b1;
            w_stateNext = DS_HOLD;
            if (bus.we2 && !w_full) begin
               w_wrAEn   = 1'b1;
               w_wrAData = bus.wdata2;
               w_wrAAddr = bus.waddr2;
               w_pushN   = 2'd1;
            end
         end
      end else begin
         if (bus.we1) begin
            if (w_full) begin
               w_overflowSet = 1'b1;
            end else begin
               w_wrAEn = 1'b1;
               w_wrBEn = bus.we2;
               w_pushN = bus.we2 ? 2'd2 : 2'd1;
            end
         end
         if (r_state == DS_HOLD) begin
            if (bus.re1) begin
               w_issueN     = 2'd1;
               w_brPendNext = 1'b0;
               w_stateNext  = NORMAL;
            end
         end else if (bus.re1 && w_geOne) begin
            w_popN       = (bus.re2 && w_geTwo) ? 2'd2 : 2'd1;
            w_issueN     = w_popN;
            w_brPendNext = bus.master_is_branch;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= NORMAL;
      else        r_state <= w_stateNext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_count     <= '0;
         r_brPend    <= 1'b0;
         r_overflow  <= 1'b0;
         r_issuedCnt <= '0;
         r_dsData    <= '0;
         r_dsAddr    <= '0;
      end else begin
         if (w_fifoClear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
         end else begin
            r_wrPtr <= r_wrPtr + PTR_W'(w_pushN);
            r_rdPtr <= r_rdPtr + PTR_W'(w_popN);
            r_count <= r_count + CNT_W'(w_pushN) - CNT_W'(w_popN);
         end
         r_brPend    <= w_brPendNext;
         r_issuedCnt <= r_issuedCnt + 64'(w_issueN);
         if (w_overflowSet) r_overflow <= 1'b1;
         if (w_dsLoad) begin
            r_dsData <= w_dsLoadData;
            r_dsAddr <= w_dsLoadAddr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wrAEn) begin
         r_memData[r_wrPtr] <= w_wrAData;
         r_memAddr[r_wrPtr] <= w_wrAAddr;
      end
      if (w_wrBEn) begin
         r_memData[w_wrPtrPlus1] <= bus.wdata2;
         r_memAddr[w_wrPtrPlus1] <= bus.waddr2;
      end
   end

   // Read ports only ever show entries present before the edge; invalid ports read as zero.
   always_comb begin
      bus.rdata1  = '0;
      bus.raddr1  = '0;
      bus.rdata2  = '0;
      bus.raddr2  = '0;
      bus.rvalid1 = 1'b0;
      bus.rvalid2 = 1'b0;
      bus.ds_out1 = 1'b0;
      case (r_state)
         NORMAL: begin
            bus.rvalid1 = w_geOne;
            bus.rvalid2 = w_geTwo;
            bus.ds_out1 = r_brPend;
            if (w_geOne) begin
               bus.rdata1 = r_memData[r_rdPtr];
               bus.raddr1 = r_memAddr[r_rdPtr];
            end
            if (w_geTwo) begin
               bus.rdata2 = r_memData[w_rdPtrPlus1];
               bus.raddr2 = r_memAddr[w_rdPtrPlus1];
            end
         end
         DS_HOLD: begin
            bus.rvalid1 = 1'b1;
            bus.ds_out1 = 1'b1;
            bus.rdata1  = r_dsData;
            bus.raddr1  = r_dsAddr;
         end
         default: ;
      endcase
   end

   assign bus.count        = r_count;
   assign bus.empty        = (r_count == '0);
   assign bus.almost_empty = (r_count == CNT_W'(1));
   assign bus.full         = w_full;
   assign bus.overflow     = r_overflow;
   assign bus.issued_cnt   = r_issuedCnt;
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue at DEPTH=8: overflow, dual push/pop, delay-slot
// flush paths, branch tracking, pointer wrap and asynchronous reset.
module tb_inst_queue;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   inst_queue_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(4)) bus ();

   inst_queue #(.DEPTH(8), .DATA_W(32), .ADDR_W(32), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] addrOf(input logic [31:0] d);
      return 32'h1000 + d;
   endfunction

   // Every comparison funnels through here so the tallies stay honest.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic we1, input logic we2,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic re1, input logic re2, input logic br,
                                input logic fl, input logic keep);
      bus.we1              = we1;
      bus.we2              = we2;
      bus.wdata1           = d1;
      bus.waddr1           = addrOf(d1);
      bus.wdata2           = d2;
      bus.waddr2           = addrOf(d2);
      bus.re1              = re1;
      bus.re2              = re2;
      bus.master_is_branch = br;
      bus.flush            = fl;
      bus.flush_keep_ds    = keep;
   endtask

   task automatic clockCycle();
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_rdata1"}, bus.rdata1, 0);
      checkOutput({tag, "_raddr1"}, bus.raddr1, 0);
      checkOutput({tag, "_rdata2"}, bus.rdata2, 0);
      checkOutput({tag, "_raddr2"}, bus.raddr2, 0);
      checkOutput({tag, "_rvalid1"}, bus.rvalid1, 0);
      checkOutput({tag, "_rvalid2"}, bus.rvalid2, 0);
      checkOutput({tag, "_ds_out1"}, bus.ds_out1, 0);
      checkOutput({tag, "_count"}, bus.count, 0);
      checkOutput({tag, "_empty"}, bus.empty, 1);
      checkOutput({tag, "_almost_empty"}, bus.almost_empty, 0);
      checkOutput({tag, "_full"}, bus.full, 0);
      checkOutput({tag, "_overflow"}, bus.overflow, 0);
      checkOutput({tag, "_issued"}, bus.issued_cnt, 0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkResetOutputs("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clockCycle();

      // Fill to full with singles, then a dual write that must be dropped.
      for (int i = 1; i <= 7; i++) begin
         applyStimulus(1'b1, 1'b0, 32'(i), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         clockCycle();
         if (i == 1) checkOutput("fill_almost_empty", bus.almost_empty, 1);
         if (i == 6) checkOutput("fill_not_full_at6", bus.full, 0);
      end
      checkOutput("fill_full", bus.full, 1);
      applyStimulus(1'b1, 1'b1, 32'h8, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      checkOutput("ovf_count", bus.count, 7);
      checkOutput("ovf_flag", bus.overflow, 1);
      checkOutput("ovf_rdata2", bus.rdata2, 2);
      checkOutput("ovf_raddr1", bus.raddr1, 32'h1001);

      for (int i = 1; i <= 7; i++) begin
         checkOutput($sformatf("drain_rdata1_%0d", i), bus.rdata1, 64'(i));
         applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         clockCycle();
      end
      checkOutput("drain_empty", bus.empty, 1);
      checkOutput("drain_rvalid1", bus.rvalid1, 0);
      checkOutput("drain_issued", bus.issued_cnt, 7);
      checkOutput("drain_ovf_sticky", bus.overflow, 1);

      // Simultaneous dual pop and dual push with A,B,C resident.
      applyStimulus(1'b1, 1'b1, 32'hA, 32'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      applyStimulus(1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      checkOutput("pp_count_pre", bus.count, 3);
      applyStimulus(1'b1, 1'b1, 32'hD, 32'hE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("pp_rdata1_same", bus.rdata1, 32'hA);
      checkOutput("pp_rdata2_same", bus.rdata2, 32'hB);
      clockCycle();
      checkOutput("pp_count_post", bus.count, 3);
      checkOutput("pp_rdata1_post", bus.rdata1, 32'hC);
      checkOutput("pp_rdata2_post", bus.rdata2, 32'hD);
      checkOutput("pp_issued", bus.issued_cnt, 9);

      // Flush keeping the delay slot: queue is C,D,E so D is kept.
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      clockCycle();
      checkOutput("dsk_rdata1", bus.rdata1, 32'hD);
      checkOutput("dsk_raddr1", bus.raddr1, 32'h100D);
      checkOutput("dsk_ds_out1", bus.ds_out1, 1);
      checkOutput("dsk_rvalid1", bus.rvalid1, 1);
      checkOutput("dsk_rvalid2", bus.rvalid2, 0);
      checkOutput("dsk_count", bus.count, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      clockCycle();
      checkOutput("dsk_pop_empty", bus.empty, 1);
      checkOutput("dsk_pop_rvalid1", bus.rvalid1, 0);
      checkOutput("dsk_pop_ds_out1", bus.ds_out1, 0);
      checkOutput("dsk_pop_issued", bus.issued_cnt, 10);

      // Branch tracking on port 1.
      applyStimulus(1'b1, 1'b1, 32'h46, 32'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      clockCycle();
      checkOutput("br_rdata1", bus.rdata1, 32'h47);
      checkOutput("br_ds_out1", bus.ds_out1, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      checkOutput("br_clear_ds_out1", bus.ds_out1, 0);
      checkOutput("br_issued", bus.issued_cnt, 12);

      // Flush-keep with one entry and no write: wait for the slot instruction.
      applyStimulus(1'b1, 1'b0, 32'h48, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      clockCycle();
      checkOutput("dsw_rvalid1", bus.rvalid1, 0);
      checkOutput("dsw_count", bus.count, 0);
      applyStimulus(1'b1, 1'b1, 32'h58, 32'h59, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      checkOutput("dsw_rdata1", bus.rdata1, 32'h58);
      checkOutput("dsw_raddr1", bus.raddr1, 32'h1058);
      checkOutput("dsw_ds_out1", bus.ds_out1, 1);
      checkOutput("dsw_rvalid2", bus.rvalid2, 0);
      checkOutput("dsw_count", bus.count, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      clockCycle();
      checkOutput("dsw_y_rdata1", bus.rdata1, 32'h59);
      checkOutput("dsw_y_count", bus.count, 1);
      checkOutput("dsw_y_ds_out1", bus.ds_out1, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      checkOutput("dsw_issued", bus.issued_cnt, 14);

      // Flush-keep with one entry and we1 high, then a plain flush out of DS_HOLD.
      applyStimulus(1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      applyStimulus(1'b1, 1'b0, 32'h61, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      clockCycle();
      checkOutput("dsi_rdata1", bus.rdata1, 32'h61);
      checkOutput("dsi_count", bus.count, 0);
      applyStimulus(1'b1, 1'b0, 32'h62, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      clockCycle();
      checkOutput("fl_rvalid1", bus.rvalid1, 0);
      checkOutput("fl_empty", bus.empty, 1);
      checkOutput("fl_issued", bus.issued_cnt, 14);

      // Pointer wrap: 20 push/pop pairs with one entry always resident.
      applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(1'b1, 1'b0, 32'(32'h100 + i), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         checkOutput($sformatf("wrap_rdata1_%0d", i), bus.rdata1, 64'(32'h100 + i - 1));
         clockCycle();
         checkOutput($sformatf("wrap_count_%0d", i), bus.count, 1);
      end
      checkOutput("wrap_last", bus.rdata1, 32'h114);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      checkOutput("wrap_issued", bus.issued_cnt, 35);

      // Asynchronous reset mid-operation with five entries queued.
      applyStimulus(1'b1, 1'b1, 32'h70, 32'h71, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      applyStimulus(1'b1, 1'b1, 32'h72, 32'h73, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      applyStimulus(1'b1, 1'b0, 32'h74, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clockCycle();
      checkOutput("ar_count_pre", bus.count, 5);
      #3;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("async_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entry count; power of two, at least 4.
REQ-002 SHALL have parameter DATA_W, default 32: instruction width.
REQ-003 SHALL have parameter ADDR_W, default 32: PC width.
REQ-004 SHALL have parameter CNT_W, default $clog2(DEPTH)+1: occupancy width.
REQ-005 clk  in  1: the single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1: asynchronous, active-low reset.
REQ-007 flush  in  1: discard queue contents, single-cycle pulse.
REQ-008 flush_keep_ds  in  1: qualifies flush; when high, preserve the delay-slot instruction.
REQ-009 master_is_branch  in  1: instruction issued on port 1 this cycle is a branch.
REQ-010 we1, we2  in  1 each: write enables; we2 is valid only together with we1.
REQ-011 wdata1, wdata2  in  DATA_W each: instructions to write.
REQ-012 waddr1, waddr2  in  ADDR_W each: PCs of the instructions to write.
REQ-013 re1, re2  in  1 each: pop enables; re2 is valid only together with re1.
REQ-014 rdata1, rdata2  out  DATA_W each: head and head+1 instructions.
REQ-015 raddr1, raddr2  out  ADDR_W each: head and head+1 PCs.
REQ-016 rvalid1, rvalid2  out  1 each: read ports hold real entries.
REQ-017 ds_out1  out  1: the port-1 instruction is in a delay slot.
REQ-018 count  out  CNT_W: current occupancy.
REQ-019 empty, almost_empty, full  out  1 each: queue status flags.
REQ-020 overflow  out  1: sticky; a write was dropped.
REQ-021 issued_cnt  out  64: total entries popped.

Function
REQ-022 Storage SHALL hold DEPTH entries of {data, addr}; read/write pointers wrap modulo DEPTH.
REQ-023 Flags SHALL be combinational: empty = (count==0); almost_empty = (count==1); full = (count > DEPTH-2).
REQ-024 Writes: we1 alone pushes 1 entry; we1&we2 pushes 2 entries in order; we2 without we1 is ignored.
REQ-025 Writes while full SHALL be dropped entirely (no partial push) and SHALL set overflow.
REQ-026 Pops: re1 pops 1 entry; re1&re2 pops 2 entries; pop count is limited to the pre-edge count; re2 without re1 is ignored.
REQ-027 Same-cycle push and pop: count_next = count + pushed - popped; no write-to-read bypass; read ports see only entries present before the edge.
REQ-028 NORMAL state port 1: rvalid1 = (count>=1).
REQ-029 NORMAL state port 2: rvalid2 = (count>=2).
REQ-030 Any invalid read port SHALL output all-zero data and address.
REQ-031 Branch tracking: a pop on port 1 with master_is_branch high SHALL set br_pend; any other port-1 pop clears it; in NORMAL, ds_out1 = br_pend.
REQ-032 FSM states: NORMAL, DS_WAIT, DS_HOLD.
REQ-033 flush with flush_keep_ds low (any state): next cycle count=0, pointers=0, state=NORMAL, br_pend=0; same-cycle writes and pops discarded.
REQ-034 flush with flush_keep_ds high, count>=2: FIFO cleared; the head+1 entry is copied into ds_reg; state becomes DS_HOLD.
REQ-035 flush with flush_keep_ds high, count<2 and we1 high: FIFO cleared; wdata1/waddr1 are copied into ds_reg; state becomes DS_HOLD.
REQ-036 flush with flush_keep_ds high, count<2 and we1 low: FIFO cleared; state becomes DS_WAIT.
REQ-037 In DS_WAIT, rvalid1=0 and rvalid2=0; the first we1 loads ds_reg and moves the state to DS_HOLD; a same-cycle we2 entry is pushed into the FIFO.
REQ-038 In DS_HOLD, port 1 presents ds_reg with rvalid1=1 and ds_out1=1; rvalid2=0; FIFO writes proceed normally.
REQ-039 In DS_HOLD, re1 consumes ds_reg and returns the state to NORMAL; re2 is ignored; br_pend clears.
REQ-040 A flush arriving in DS_WAIT or DS_HOLD SHALL discard ds_reg and re-apply REQ-033 to REQ-036.
REQ-041 issued_cnt SHALL increment by the number of entries actually popped, including a ds_reg pop, and SHALL wrap at 2^64.

Reset
REQ-042 While rst_n is low: pointers=0, count=0, state=NORMAL, br_pend=0, overflow=0, issued_cnt=0, ds_reg=0.
REQ-043 Reset outputs: all rdata/raddr=0, rvalid1=0, rvalid2=0, ds_out1=0, empty=1, almost_empty=0, full=0.
REQ-044 Storage array SHALL NOT be reset; reset deassertion is synchronised externally.

Verification (DEPTH=8)
REQ-045 Push 7 single entries, then we1&we2 -> count=7, full=1, second push dropped, overflow=1.
REQ-046 count=3 (A,B,C), re1&re2 with we1&we2 (D,E) -> rdata1=A, rdata2=B that cycle; next cycle count=3, rdata1=C.
REQ-047 count=3 (A,B,C), flush&keep -> next cycle rdata1=B, ds_out1=1, rvalid2=0; then re1 -> NORMAL, empty=1, issued_cnt+1.
REQ-048 count=1, flush&keep, we1 low; two cycles later we1&we2 (X,Y) -> DS_WAIT then DS_HOLD; rdata1=X with ds_out1=1; FIFO count=1 holding Y.
REQ-049 Pointer wrap: 20 push/pop pairs -> data order preserved, count stays within 0..8.
REQ-050 rst_n low mid-operation with count=5 -> outputs match REQ-043 immediately, without waiting for a clock edge.
